// File: rtl/qpmm_seq_mul.sv
// Digit-serial Montgomery multiplier with Orup-style quotient selection (q = low digit of S).
// The result z is congruent to a*b*2^(-K*N) mod M but is not reduced below M.
module qpmm_seq_mul #(
  parameter int K  = 16,
  parameter int N  = 17,
  parameter int W  = K * N,
  parameter int SW = K * N + K + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  mpp,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] z,
  output logic          busy
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  mpp_q;
  logic [SW-1:0] s_q, s_d;
  logic [CW-1:0] i_q;

  logic          accept;
  logic          last_iter;
  logic [K-1:0]  q_dig;
  logic [K-1:0]  b_dig;
  logic [SW-1:0] q_term;
  logic [SW-1:0] b_term;

  assign accept    = in_valid & in_ready;
  assign last_iter = (i_q == CW'(N));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RUN;
      ST_RUN:  if (last_iter) state_d = ST_DONE;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // z is gated to zero outside DONE so a partial accumulator never reaches the port.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    z         = '0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_RUN:  busy     = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        z         = s_q;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // B is shifted down a digit per iteration, so the extra (N+1)-th iteration sees b_N = 0.
  assign q_dig  = s_q[K-1:0];
  assign b_dig  = b_q[K-1:0];
  assign q_term = SW'(q_dig) * SW'(mpp_q);
  assign b_term = SW'(b_dig) * SW'(a_q);
  assign s_d    = (s_q >> K) + q_term + b_term;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      mpp_q <= '0;
      s_q   <= '0;
      i_q   <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      mpp_q <= mpp;
      s_q   <= '0;
      i_q   <= '0;
    end else if (state_q == ST_RUN) begin
      s_q   <= s_d;
      b_q   <= b_q >> K;
      i_q   <= i_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_qpmm_seq_mul.sv
// Bench for qpmm_seq_mul: a small K=4,N=2 instance (M=13) and the default K=16,N=17 instance
// checked by modular congruence z*2^(K*N) == a*b (mod M) computed with wide arithmetic.
`timescale 1ns/1ps
module tb_qpmm_seq_mul;
  localparam int SK = 4;
  localparam int SN = 2;
  localparam int SWD = SK * SN;
  localparam int SSW = SK * SN + SK + 2;
  localparam int BK = 16;
  localparam int BN = 17;
  localparam int BWD = BK * BN;
  localparam int BSW = BK * BN + BK + 2;
  localparam int XW = 600;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b0, s_busy;
  logic [SWD-1:0] s_a = '0, s_b = '0, s_mpp = '0;
  logic [SSW-1:0] s_z;
  logic           b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_busy;
  logic [BWD-1:0] b_a = '0, b_b = '0, b_mpp = '0;
  logic [BSW-1:0] b_z;

  qpmm_seq_mul #(.K(SK), .N(SN)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .a(s_a), .b(s_b), .mpp(s_mpp), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .z(s_z), .busy(s_busy)
  );

  qpmm_seq_mul #(.K(BK), .N(BN)) u_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .a(b_a), .b(b_b), .mpp(b_mpp), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .z(b_z), .busy(b_busy)
  );

  int checks = 0;
  int failures = 0;

  // Odd 254-bit BN prime; mpp for the default instance is derived from it below.
  logic [BWD-1:0] p_bn = 272'h2523648240000001BA344D80000000086121000000000013A700000000000013;
  logic [BWD-1:0] mpp_bn;

  task automatic chk(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BWD-1:0] rand272();
    logic [BWD-1:0] r;
    r = '0;
    for (int k = 0; k < 9; k++) r = {r[BWD-33:0], 32'($urandom)};
    return r;
  endfunction

  task automatic s_start(input logic [SWD-1:0] av, input logic [SWD-1:0] bv);
    s_a = av; s_b = bv; s_mpp = 8'd9; s_in_valid = 1'b1;
    chk("s_in_ready_idle", XW'(s_in_ready), XW'(1));
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    s_a = 8'($urandom); s_b = 8'($urandom); s_mpp = 8'($urandom);
  endtask

  // Cycles are numbered from 1, starting with the cycle that follows the accept edge.
  task automatic s_wait(output logic [SSW-1:0] zo);
    int lat;
    lat = 1;
    while (!s_out_valid && lat < 50) begin
      chk("s_in_ready_run", XW'(s_in_ready), XW'(0));
      chk("s_busy_run", XW'(s_busy), XW'(1));
      @(posedge clk); #1;
      lat++;
    end
    chk("s_latency", XW'(lat), XW'(SN + 2));
    chk("s_in_ready_done", XW'(s_in_ready), XW'(0));
    chk("s_busy_done", XW'(s_busy), XW'(0));
    zo = s_z;
  endtask

  task automatic s_release();
    s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    chk("s_out_valid_drop", XW'(s_out_valid), XW'(0));
    chk("s_in_ready_back", XW'(s_in_ready), XW'(1));
  endtask

  task automatic b_op(input logic [BWD-1:0] av, input logic [BWD-1:0] bv, output logic [BSW-1:0] zo);
    int lat;
    b_a = av; b_b = bv; b_mpp = mpp_bn; b_in_valid = 1'b1;
    chk("b_in_ready_idle", XW'(b_in_ready), XW'(1));
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_a = rand272(); b_b = rand272(); b_mpp = rand272();
    lat = 1;
    while (!b_out_valid && lat < 100) begin
      chk("b_busy_run", XW'(b_busy), XW'(1));
      @(posedge clk); #1;
      lat++;
    end
    chk("b_latency", XW'(lat), XW'(BN + 2));
    zo = b_z;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
    chk("b_out_valid_drop", XW'(b_out_valid), XW'(0));
  endtask

  initial begin
    logic [SSW-1:0] sz, sz0;
    logic [BSW-1:0] bz;
    logic [BWD-1:0] av, bv, one136;
    logic [299:0]   mtil;
    logic [XW-1:0]  lhs, rhs;
    int unsigned    p_lo, tinv;

    // M_tilda = p*t with t = -p^-1 mod 2^16, so M_tilda == -1 mod 2^16 and mpp = (M_tilda+1)/2^16.
    p_lo = 32'(p_bn[15:0]);
    tinv = 0;
    for (int unsigned t = 1; t < 65536; t += 2)
      if ((((p_lo * t) + 32'd1) & 32'hFFFF) == 32'd0) tinv = t;
    mtil = 300'(p_bn) * 300'(tinv);
    mpp_bn = BWD'((mtil + 300'd1) >> 16);

    // Reset values
    @(posedge clk); #1;
    chk("rst_s_in_ready", XW'(s_in_ready), XW'(1));
    chk("rst_s_out_valid", XW'(s_out_valid), XW'(0));
    chk("rst_s_busy", XW'(s_busy), XW'(0));
    chk("rst_s_z", XW'(s_z), XW'(0));
    chk("rst_b_in_ready", XW'(b_in_ready), XW'(1));
    chk("rst_b_z", XW'(b_z), XW'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Small config: 2^-8 mod 13 = 3 (256 == 9, 9*3 == 1 mod 13)
    s_start(8'd1, 8'd1);
    s_wait(sz);
    chk("s_one", XW'(sz % SSW'(13)), XW'(3));
    s_release();

    // out_ready held high during RUN must not end the operation early
    s_out_ready = 1'b1;
    s_start(8'd0, 8'd200);
    s_wait(sz);
    chk("s_a_zero", XW'(sz), XW'(0));
    s_release();
    s_start(8'd255, 8'd255);
    s_wait(sz);
    chk("s_max", XW'(sz % SSW'(13)), XW'((255 * 255 * 3) % 13));
    s_release();
    s_start(8'd173, 8'd0);
    s_wait(sz);
    chk("s_b_zero", XW'(sz), XW'(0));
    s_release();

    // Backpressure: result held, in_valid ignored while in DONE
    s_start(8'd77, 8'd123);
    s_wait(sz0);
    chk("s_bp_value", XW'(sz0 % SSW'(13)), XW'((77 * 123 * 3) % 13));
    for (int k = 0; k < 10; k++) begin
      s_in_valid = k[0];
      s_a = 8'($urandom); s_b = 8'($urandom);
      @(posedge clk); #1;
      chk("s_bp_out_valid", XW'(s_out_valid), XW'(1));
      chk("s_bp_z_stable", XW'(s_z), XW'(sz0));
      chk("s_bp_in_ready", XW'(s_in_ready), XW'(0));
    end
    // in_valid and out_ready together in DONE: only the output handshake happens
    s_a = 8'd1; s_b = 8'd1; s_mpp = 8'd9; s_in_valid = 1'b1; s_out_ready = 1'b1;
    @(posedge clk); #1;
    s_out_ready = 1'b0;
    chk("s_both_out_valid", XW'(s_out_valid), XW'(0));
    chk("s_both_idle", XW'(s_in_ready), XW'(1));
    chk("s_both_busy", XW'(s_busy), XW'(0));
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    chk("s_next_accept_busy", XW'(s_busy), XW'(1));
    s_wait(sz);
    chk("s_next_value", XW'(sz % SSW'(13)), XW'(3));
    s_release();

    // Reset in the middle of a default-config run, at iteration i=5
    b_a = rand272(); b_b = rand272(); b_mpp = mpp_bn; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy_before", XW'(b_busy), XW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", XW'(b_in_ready), XW'(1));
    chk("mid_rst_out_valid", XW'(b_out_valid), XW'(0));
    chk("mid_rst_busy", XW'(b_busy), XW'(0));
    chk("mid_rst_z", XW'(b_z), XW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_after_out_valid", XW'(b_out_valid), XW'(0));
    s_start(8'd1, 8'd1);
    s_wait(sz);
    chk("s_after_reset", XW'(sz % SSW'(13)), XW'(3));
    s_release();

    // Default config: 2^136 * 2^136 * 2^-272 == 1 mod p
    one136 = BWD'(1) << 136;
    b_op(one136, one136, bz);
    chk("bn_one", XW'(bz) % XW'(p_bn), XW'(1));

    // Randomised operands below p, mpp/a/b on the port scrambled during RUN
    for (int n = 0; n < 1000; n++) begin
      av = rand272() % p_bn;
      bv = rand272() % p_bn;
      b_op(av, bv, bz);
      lhs = (XW'(bz) << BWD) % XW'(p_bn);
      rhs = (XW'(av) * XW'(bv)) % XW'(p_bn);
      chk("rand_congruence", lhs, rhs);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
